// File: rtl/psk_pkg.sv
// rtl/psk_pkg.sv - shared PSK type codes, amplitudes and bits-per-symbol helper
//
// Purpose: constants and small helpers shared by the PSK mapper and the
// hard decision decoder, so both sides agree on codes and constellation.
// Ports: none (package).

package psk_pkg;

  // psk_type codes as seen on the psk_type bus.
  typedef enum logic [2:0] {
    QPSK  = 3'b001,
    PSK_8 = 3'b010
  } psk_type_e;

  // Internal latched modulation; any unknown psk_type code falls back to QPSK.
  typedef enum logic {
    MODE_QPSK = 1'b0,
    MODE_8PSK = 1'b1
  } psk_mode_e;

  // Output sequencer phase at 2 samples/symbol.
  typedef enum logic {
    PH_EVEN = 1'b0,
    PH_ODD  = 1'b1
  } phase_e;

  localparam int AMP_QPSK_DEFAULT = 180;
  localparam int AMP_HI_DEFAULT   = 256;
  localparam int AMP_LO_DEFAULT   = 98;

  function automatic psk_mode_e to_mode(input logic [2:0] psk_type);
    return (psk_type == PSK_8) ? MODE_8PSK : MODE_QPSK;
  endfunction

  function automatic logic [1:0] bits_per_symbol(input psk_mode_e mode);
    return (mode == MODE_8PSK) ? 2'd3 : 2'd2;
  endfunction

endpackage

// File: rtl/psk_point_map.sv
// rtl/psk_point_map.sv - combinational symbol to constellation point mapper
//
// Purpose: maps a QPSK (2-bit) or 8-PSK (3-bit) symbol onto the same I/Q
// points the hard decision decoder emits.
// Ports:
//   mode_8psk_i  1         1 = 8-PSK, 0 = QPSK
//   sym_i        3         symbol, first received bit in the MSB used
//                          (QPSK uses sym_i[1:0], 8-PSK uses sym_i[2:0])
//   i_o / q_o    IQ_WIDTH  signed constellation point

module psk_point_map #(
  parameter int IQ_WIDTH = 10,
  parameter int AMP_QPSK = 180,
  parameter int AMP_HI   = 256,
  parameter int AMP_LO   = 98
) (
  input  logic                       mode_8psk_i,
  input  logic [2:0]                 sym_i,
  output logic signed [IQ_WIDTH-1:0] i_o,
  output logic signed [IQ_WIDTH-1:0] q_o
);

  localparam logic signed [IQ_WIDTH-1:0] P_QPSK = IQ_WIDTH'(AMP_QPSK);
  localparam logic signed [IQ_WIDTH-1:0] N_QPSK = IQ_WIDTH'(-AMP_QPSK);
  localparam logic signed [IQ_WIDTH-1:0] P_HI   = IQ_WIDTH'(AMP_HI);
  localparam logic signed [IQ_WIDTH-1:0] N_HI   = IQ_WIDTH'(-AMP_HI);
  localparam logic signed [IQ_WIDTH-1:0] P_LO   = IQ_WIDTH'(AMP_LO);
  localparam logic signed [IQ_WIDTH-1:0] N_LO   = IQ_WIDTH'(-AMP_LO);

  always_comb begin
    i_o = '0;
    q_o = '0;
    if (mode_8psk_i) begin
      // b2/b1 pick the quadrant, b0 picks which axis carries the large magnitude.
      if (sym_i[0]) begin
        i_o = sym_i[2] ? P_HI : N_HI;
        q_o = sym_i[1] ? P_LO : N_LO;
      end else begin
        i_o = sym_i[2] ? P_LO : N_LO;
        q_o = sym_i[1] ? P_HI : N_HI;
      end
    end else begin
      i_o = sym_i[1] ? P_QPSK : N_QPSK;
      q_o = sym_i[0] ? P_QPSK : N_QPSK;
    end
  end

endmodule

// File: rtl/psk_symbol_mapper.sv
// rtl/psk_symbol_mapper.sv - serial bit stream to QPSK/8-PSK IQ samples at 2 sps
//
// Purpose: packs input bits into symbols, maps them to constellation points and
// emits point / zero sample pairs on the sample strobe.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   psk_type   in  3   001 QPSK, 010 8-PSK, others QPSK (sampled per symbol)
//   i_bit_val  in  1   input bit valid
//   i_bit      in  1   input bit, symbol MSB first
//   o_bit_rdy  out 1   a bit can be accepted this cycle
//   i_smp_en   in  1   output sample strobe
//   o_val      out 1   i_smp_en delayed by one cycle
//   o_data_I/Q out IQ_WIDTH signed output sample (registered)
//   o_underflow out 1  pulse: even slot found no symbol in hold

module psk_symbol_mapper
  import psk_pkg::*;
#(
  parameter int IQ_WIDTH = 10,
  parameter int AMP_QPSK = AMP_QPSK_DEFAULT,
  parameter int AMP_HI   = AMP_HI_DEFAULT,
  parameter int AMP_LO   = AMP_LO_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [2:0]                 psk_type,
  input  logic                       i_bit_val,
  input  logic                       i_bit,
  output logic                       o_bit_rdy,
  input  logic                       i_smp_en,
  output logic                       o_val,
  output logic signed [IQ_WIDTH-1:0] o_data_I,
  output logic signed [IQ_WIDTH-1:0] o_data_Q,
  output logic                       o_underflow
);

  // Bit assembly
  logic [1:0]                 cnt_q, cnt_d;
  logic [2:0]                 sr_q, sr_d;
  psk_mode_e                  mode_q, mode_d;
  // One-symbol hold buffer between assembly and the sequencer
  logic                       hold_full_q, hold_full_d;
  logic signed [IQ_WIDTH-1:0] hold_i_q, hold_i_d;
  logic signed [IQ_WIDTH-1:0] hold_q_q, hold_q_d;
  // Output sequencer and registered outputs
  phase_e                     phase_q, phase_d;
  logic                       val_q, val_d;
  logic signed [IQ_WIDTH-1:0] data_i_q, data_i_d;
  logic signed [IQ_WIDTH-1:0] data_q_q, data_q_d;
  logic                       uf_q, uf_d;

  logic [1:0]                 bps;
  logic                       bit_acc;
  logic                       sym_done;
  logic                       consume;
  logic                       xfer;
  logic signed [IQ_WIDTH-1:0] map_i, map_q;

  assign bps       = bits_per_symbol(mode_q);
  assign o_bit_rdy = (cnt_q != bps);
  assign bit_acc   = i_bit_val && o_bit_rdy;
  assign sym_done  = (cnt_q == bps);
  // Hold may be refilled in the same cycle the sequencer drains it.
  assign xfer      = sym_done && (!hold_full_q || consume);

  psk_point_map #(
    .IQ_WIDTH (IQ_WIDTH),
    .AMP_QPSK (AMP_QPSK),
    .AMP_HI   (AMP_HI),
    .AMP_LO   (AMP_LO)
  ) u_point_map (
    .mode_8psk_i (mode_q == MODE_8PSK),
    .sym_i       (sr_q),
    .i_o         (map_i),
    .q_o         (map_q)
  );

  // ---------------- bit assembly and hold ----------------
  always_comb begin
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    mode_d      = mode_q;
    hold_full_d = hold_full_q;
    hold_i_d    = hold_i_q;
    hold_q_d    = hold_q_q;

    // Mode is only sampled between symbols so a mid-symbol change waits.
    if (cnt_q == 2'd0) begin
      mode_d = to_mode(psk_type);
    end

    if (xfer) begin
      cnt_d = 2'd0;
    end else if (bit_acc) begin
      cnt_d = cnt_q + 2'd1;
    end

    if (bit_acc) begin
      sr_d = {sr_q[1:0], i_bit};
    end

    if (xfer) begin
      hold_full_d = 1'b1;
      hold_i_d    = map_i;
      hold_q_d    = map_q;
    end else if (consume) begin
      hold_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= 2'd0;
      sr_q        <= 3'd0;
      mode_q      <= MODE_QPSK;
      hold_full_q <= 1'b0;
      hold_i_q    <= '0;
      hold_q_q    <= '0;
    end else begin
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      mode_q      <= mode_d;
      hold_full_q <= hold_full_d;
      hold_i_q    <= hold_i_d;
      hold_q_q    <= hold_q_d;
    end
  end

  // ---------------- output sequencer ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= PH_EVEN;
    end else begin
      phase_q <= phase_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    if (i_smp_en) begin
      phase_d = (phase_q == PH_EVEN) ? PH_ODD : PH_EVEN;
    end
  end

  always_comb begin
    consume  = 1'b0;
    uf_d     = 1'b0;
    val_d    = i_smp_en;
    data_i_d = data_i_q;
    data_q_d = data_q_q;
    if (i_smp_en) begin
      // Odd slots and starved even slots both emit a null sample.
      data_i_d = '0;
      data_q_d = '0;
      if (phase_q == PH_EVEN) begin
        if (hold_full_q) begin
          consume  = 1'b1;
          data_i_d = hold_i_q;
          data_q_d = hold_q_q;
        end else begin
          uf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      val_q    <= 1'b0;
      data_i_q <= '0;
      data_q_q <= '0;
      uf_q     <= 1'b0;
    end else begin
      val_q    <= val_d;
      data_i_q <= data_i_d;
      data_q_q <= data_q_d;
      uf_q     <= uf_d;
    end
  end

  assign o_val       = val_q;
  assign o_data_I    = data_i_q;
  assign o_data_Q    = data_q_q;
  assign o_underflow = uf_q;

endmodule
